// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
//
// Single-outstanding APB4 requester. A command accepted on the valid/ready
// interface becomes one SETUP + ACCESS transfer. The completion status is then
// held on the rsp_* outputs until it is consumed. Every ACCESS phase is bounded
// by a wait-state timeout. When the timeout fires, the transfer is aborted and
// reported as an error.
//
// State table
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | cmd_ready=1, waiting for a command
//   S_SETUP  | psel=1, penable=0, wait counter cleared
//   S_ACCESS | psel=1, penable=1, waiting for pready or timeout
//   S_RESP   | bus idle, rsp_valid=1 held until rsp_ready
//
// Ports
//   pclk, rst         clock, asynchronous active-high reset
//   cmd_valid/ready   command handshake (cmd_ready decoded from state)
//   cmd_write         1 = write, 0 = read
//   cmd_addr          byte address
//   cmd_wdata         write data
//   cmd_strb          write byte strobes
//   rsp_valid/ready   response handshake, response held until consumed
//   rsp_rdata         read data (0 for writes and timeouts)
//   rsp_err           pslverr or timeout
//   rsp_timeout       transfer aborted by timeout
//   psel..pstrb       APB requester outputs (all registered)
//   pready, prdata,
//   pslverr           APB completer inputs
// -----------------------------------------------------------------------------
module apb_master #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                    pclk,
    input  logic                    rst,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,

    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic                    pready,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pslverr
);

    localparam int CNT_WIDTH = $clog2(TIMEOUT) + 1;
    localparam bit TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    // The limit value is only used when the timeout is enabled.
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = TIMEOUT_EN ? CNT_WIDTH'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                 r_state;
    logic [CNT_WIDTH-1:0]   r_wait_cnt;
    logic                   w_timeout_hit;

    assign cmd_ready     = (r_state == S_IDLE);
    // The count equals the number of pready-low ACCESS cycles that came before
    // the current one. It hits the limit on the TIMEOUT-th ACCESS cycle.
    assign w_timeout_hit = TIMEOUT_EN && (r_wait_cnt == CNT_LIMIT);

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        pwrite     <= cmd_write;
                        paddr      <= cmd_addr;
                        // Reads carry no data and no strobes on the bus.
                        pwdata     <= cmd_write ? cmd_wdata : '0;
                        pstrb      <= cmd_write ? cmd_strb  : '0;
                        psel       <= 1'b1;
                        penable    <= 1'b0;
                        r_wait_cnt <= '0;
                        r_state    <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    penable    <= 1'b1;
                    r_wait_cnt <= '0;
                    r_state    <= S_ACCESS;
                end

                S_ACCESS: begin
                    // pready takes priority over a timeout in the same cycle.
                    if (pready) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        r_state     <= S_RESP;
                    end else if (w_timeout_hit) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_wait_cnt != CNT_MAX) begin
                        r_wait_cnt  <= r_wait_cnt + CNT_ONE;
                    end
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// -----------------------------------------------------------------------------
// tb_apb_master
//
// The driver issues commands. For each one it pushes the expected response
// into a queue. That expected response comes from a word-array memory model
// and a simple wait/timeout rule. A negedge monitor checks the bus phase and
// the held fields against the head of the queue, and pops and compares on
// every response handshake. A behavioural APB slave with its own memory
// answers with a programmable number of wait states and error responses.
// -----------------------------------------------------------------------------
module tb_apb_master;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic          pclk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_strb;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err, rsp_timeout;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;

    always #5 pclk = ~pclk;

    apb_master #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .pclk        (pclk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pstrb       (pstrb),
        .pready      (pready),
        .prdata      (prdata),
        .pslverr     (pslverr)
    );

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        logic [DW-1:0] rdata;
        logic          err;
        logic          to;
        int            lat;   // accept cycle -> first rsp_valid cycle
        int            acc;   // number of penable cycles
    } req_t;

    req_t          sb_q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;

    logic [DW-1:0] ref_mem [0:1023];
    logic [DW-1:0] smem    [0:1023];
    int            slv_wait  = 0;
    logic          slv_err   = 1'b0;
    int            acc_n     = 0;
    int            rdy_block = 0;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at t=%0t", name, $time);
    endtask

    // Behavioural APB completer: pready rises after slv_wait low ACCESS cycles.
    always @(posedge pclk) begin
        #1;
        if (psel && penable) begin
            if (acc_n >= slv_wait) begin
                pready  = 1'b1;
                pslverr = slv_err;
                if (pwrite) begin
                    prdata = $urandom;
                    if (!slv_err) begin
                        for (int b = 0; b < SW; b++)
                            if (pstrb[b]) smem[paddr[AW-1:2]][8*b +: 8] = pwdata[8*b +: 8];
                    end
                end else begin
                    prdata = smem[paddr[AW-1:2]];
                end
            end else begin
                pready  = 1'b0;
                pslverr = 1'($urandom_range(0, 1));
                prdata  = $urandom;
            end
            acc_n++;
        end else begin
            acc_n   = 0;
            pready  = 1'b0;
            pslverr = 1'b0;
            prdata  = $urandom;
        end
    end

    // Response consumer: random back-pressure, or forced low for rdy_block cycles of rsp_valid.
    always @(posedge pclk) begin
        #2;
        if (rdy_block > 0) begin
            rsp_ready = 1'b0;
            if (rsp_valid) rdy_block--;
        end else begin
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor / scoreboard.
    logic busy_m = 1'b0, psel_prev = 1'b0, rv_prev = 1'b0, hs_prev = 1'b0;
    int   pen_cnt = 0, acc_cyc = 0, rv_cyc = 0;
    req_t mx;

    always @(negedge pclk) begin
        if (rst) begin
            busy_m    = 1'b0;
            psel_prev = 1'b0;
            rv_prev   = 1'b0;
            hs_prev   = 1'b0;
            pen_cnt   = 0;
        end else begin
            chk("cmd_ready", 32'(cmd_ready), 32'(!busy_m));
            if (cmd_valid && cmd_ready) begin
                busy_m  = 1'b1;
                acc_cyc = cyc;
            end
            if (psel) begin
                if (sb_q.size() == 0) begin
                    fail_now("spurious_psel");
                end else begin
                    mx = sb_q[0];
                    chk("paddr",   32'(paddr),   32'(mx.addr));
                    chk("pwrite",  32'(pwrite),  32'(mx.wr));
                    chk("pwdata",  pwdata,       mx.wr ? mx.wdata : 32'h0);
                    chk("pstrb",   32'(pstrb),   mx.wr ? 32'(mx.strb) : 32'h0);
                    chk("penable_phase", 32'(penable), 32'(psel_prev));
                end
                if (penable) pen_cnt++;
            end else begin
                if (psel_prev && sb_q.size() != 0)
                    chk("access_cycles", 32'(pen_cnt), 32'(sb_q[0].acc));
                pen_cnt = 0;
            end
            if (rsp_valid) begin
                chk("psel_in_resp", 32'(psel), 32'h0);
                if (!rv_prev) rv_cyc = cyc;
                if (sb_q.size() == 0) begin
                    fail_now("spurious_rsp");
                end else if (rsp_ready) begin
                    mx = sb_q.pop_front();
                    chk("rsp_rdata",   rsp_rdata,         mx.rdata);
                    chk("rsp_err",     32'(rsp_err),      32'(mx.err));
                    chk("rsp_timeout", 32'(rsp_timeout),  32'(mx.to));
                    chk("rsp_latency", 32'(rv_cyc - acc_cyc), 32'(mx.lat));
                    busy_m = 1'b0;
                end
            end else if (rv_prev && !hs_prev) begin
                fail_now("rsp_dropped_before_ready");
            end
            hs_prev   = rsp_valid && rsp_ready;
            rv_prev   = rsp_valid;
            psel_prev = psel;
        end
    end

    // Called at posedge+2. Returns right after the command has been accepted.
    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic [SW-1:0] st, input int w, input logic e);
        req_t x;
        int   n;
        int   idx;
        n = 0;
        while (!cmd_ready && n < 300) begin
            @(posedge pclk);
            #2;
            n++;
        end
        if (!cmd_ready) begin
            fail_now("cmd_ready_wait_expired");
            return;
        end
        slv_wait = w;
        slv_err  = e;
        idx      = int'(addr[AW-1:2]);
        x.wr = wr; x.addr = addr; x.wdata = wd; x.strb = st;
        if (w >= TO) begin
            x.rdata = '0; x.err = 1'b1; x.to = 1'b1;
            x.lat   = 3 + TO - 1;
            x.acc   = TO;
        end else begin
            x.err = e; x.to = 1'b0;
            x.lat = 3 + w;
            x.acc = w + 1;
            if (wr) begin
                x.rdata = '0;
                if (!e) begin
                    for (int b = 0; b < SW; b++)
                        if (st[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
                end
            end else begin
                x.rdata = ref_mem[idx];
            end
        end
        sb_q.push_back(x);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_strb  = st;
        @(posedge pclk);
        #2;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = AW'($urandom);
        cmd_wdata = $urandom;
        cmd_strb  = SW'($urandom);
    endtask

    logic [AW-1:0] addr_set [8];

    initial begin
        int r, w;
        logic wr;
        addr_set = '{12'h004, 12'h008, 12'h010, 12'h014, 12'h020, 12'h7FC, 12'h800, 12'hFE0};
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = '0;
            smem[i]    = '0;
        end
        ref_mem[12'hFE0 >> 2] = 32'h0000_0019;
        smem[12'hFE0 >> 2]    = 32'h0000_0019;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        rsp_ready = 1'b0;
        pready    = 1'b0;
        prdata    = '0;
        pslverr   = 1'b0;

        repeat (3) @(posedge pclk);
        #3;
        chk("rst_psel",        32'(psel),        32'h0);
        chk("rst_penable",     32'(penable),     32'h0);
        chk("rst_pwrite",      32'(pwrite),      32'h0);
        chk("rst_paddr",       32'(paddr),       32'h0);
        chk("rst_pwdata",      pwdata,           32'h0);
        chk("rst_pstrb",       32'(pstrb),       32'h0);
        chk("rst_rsp_valid",   32'(rsp_valid),   32'h0);
        chk("rst_rsp_rdata",   rsp_rdata,        32'h0);
        chk("rst_rsp_err",     32'(rsp_err),     32'h0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 32'h0);
        @(posedge pclk);
        #2;
        rst = 1'b0;
        @(posedge pclk);
        #2;

        // Directed cases.
        issue(1'b1, 12'h004, 32'hA5A5_5A5A, 4'hF, 0, 1'b0);
        issue(1'b0, 12'h004, 32'hFFFF_FFFF, 4'hF, 0, 1'b0);
        issue(1'b0, 12'hFE0, 32'h1234_0000, 4'hA, 0, 1'b0);
        issue(1'b1, 12'h008, 32'h1234_5678, 4'h3, 3, 1'b0);
        rdy_block = 5;
        issue(1'b1, 12'h100, 32'hDEAD_BEEF, 4'hF, 0, 1'b1);
        issue(1'b0, 12'h010, 32'h0,         4'h0, 1000, 1'b0);
        issue(1'b0, 12'h004, 32'h0,         4'h0, 15, 1'b0);
        issue(1'b1, 12'h014, 32'h0BAD_F00D, 4'hF, 1000, 1'b0);
        issue(1'b0, 12'h014, 32'h0,         4'h0, 0, 1'b0);

        // Reset in the middle of an ACCESS phase of a read.
        issue(1'b0, 12'h00C, 32'h0, 4'h0, 50, 1'b0);
        repeat (4) begin
            @(posedge pclk);
            #2;
        end
        chk("pre_rst_psel",    32'(psel),    32'h1);
        chk("pre_rst_penable", 32'(penable), 32'h1);
        rst = 1'b1;
        #1;
        chk("async_rst_psel",      32'(psel),      32'h0);
        chk("async_rst_penable",   32'(penable),   32'h0);
        chk("async_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        sb_q.delete();
        @(posedge pclk);
        @(posedge pclk);
        #2;
        rst = 1'b0;
        @(posedge pclk);
        #2;
        issue(1'b0, 12'h008, 32'h0, 4'h0, 1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       w = $urandom_range(0, 3);
            else if (r == 7) w = TO - 1;
            else if (r == 8) w = TO;
            else             w = $urandom_range(4, 8);
            wr = 1'($urandom_range(0, 1));
            issue(wr, addr_set[$urandom_range(0, 7)], $urandom, SW'($urandom_range(1, 15)),
                  w, ($urandom_range(0, 7) == 0));
        end

        begin
            int n;
            n = 0;
            while ((sb_q.size() != 0 || !cmd_ready) && n < 500) begin
                @(posedge pclk);
                #2;
                n++;
            end
            if (sb_q.size() != 0) fail_now("drain_wait_expired");
        end
        @(posedge pclk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
